// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (fetch/data) memory arbiter with one transaction in flight
//
// Purpose:
//   Shares one memory port between an instruction-fetch master (I, read-only)
//   and a data master (D, read/write). Only one transaction is in flight at a
//   time: IDLE (grant) -> REQ (hold m_req until m_ack) -> RESP (valid pulse) -> IDLE.
//   D wins over I when both request.
//
// Configuration:
//   ARB_STARVE_GUARD_EN - when defined, a saturating counter tracks D grants
//   taken while I was waiting. Once it reaches STARVE_MAX, I wins the next
//   contested grant. When undefined, D has strict priority and no counter exists.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   i_req, i_addr               fetch request / address
//   i_gnt, i_valid, i_rdata     fetch accept (comb), data-valid pulse, read data
//   d_req, d_we, d_addr,
//   d_wdata                     data request / write-enable / address / write data
//   d_gnt, d_valid, d_rdata     data accept (comb), completion pulse, read data
//   m_req, m_we, m_addr,
//   m_wdata                     memory request side (registered)
//   m_ack, m_rdata              memory completion / read data
//   busy                        transaction in flight (REQ or RESP)

module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   own_d;      // in-flight transaction belongs to D
    logic   pick_d;     // D wins the current arbitration

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
    // I overrides D only when it has already waited through STARVE_MAX D grants.
    assign pick_d     = d_req && !(i_req && starve_hit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (d_gnt && i_req) begin
            if (!starve_hit) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (i_gnt) begin
            starve_cnt <= '0;
        end
    end
`else
    assign pick_d = d_req;
`endif

    // Grants are combinational in IDLE; held off during reset so nothing is
    // accepted by the edge that clears the state.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst && (state == IDLE)) begin
            d_gnt = pick_d;
            i_gnt = i_req && !pick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            own_d   <= 1'b0;
            i_valid <= 1'b0;
            i_rdata <= '0;
            d_valid <= 1'b0;
            d_rdata <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_gnt || d_gnt) begin
                        own_d   <= d_gnt;
                        m_req   <= 1'b1;
                        m_we    <= d_gnt && d_we;
                        m_addr  <= d_gnt ? d_addr : i_addr;
                        m_wdata <= d_gnt ? d_wdata : '0;
                        busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        if (own_d) begin
                            d_valid <= 1'b1;
                            // Writes return zero so stale read data never looks fresh.
                            d_rdata <= m_we ? '0 : m_rdata;
                        end else begin
                            i_valid <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    i_valid <= 1'b0;
                    d_valid <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized + directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, m_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, m_rdata;
    logic          i_gnt, i_valid, d_gnt, d_valid, m_req, m_we, busy;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model: what is in flight, whether memory has answered,
    // last delivered data per master, and how long I has been passed over.
    bit            mk      = 1'b0;
    bit            t_busy  = 1'b0;
    bit            t_acked = 1'b0;
    bit            t_d     = 1'b0;
    bit            t_we    = 1'b0;
    logic [AW-1:0] t_addr  = '0;
    logic [DW-1:0] t_wdata = '0;
    logic [DW-1:0] last_i  = '0;
    logic [DW-1:0] last_d  = '0;
    int            streak  = 0;

    bit            e_ig, e_dg, e_iv, e_dv, e_mreq, e_mwe, e_busy;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwdata, e_ir, e_dr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mk) begin
            chk("i_gnt",   i_gnt,   e_ig);
            chk("d_gnt",   d_gnt,   e_dg);
            chk("i_valid", i_valid, e_iv);
            chk("d_valid", d_valid, e_dv);
            chk("i_rdata", i_rdata, e_ir);
            chk("d_rdata", d_rdata, e_dr);
            chk("m_req",   m_req,   e_mreq);
            chk("busy",    busy,    e_busy);
            if (e_mreq) begin
                chk("m_we",   m_we,   e_mwe);
                chk("m_addr", m_addr, e_maddr);
                if (e_mwe) chk("m_wdata", m_wdata, e_mwdata);
            end
        end
    end

    // One clock cycle: drive inputs after the edge, predict outputs, then
    // advance the model to reflect the upcoming edge.
    task automatic cyc(input bit r, input bit ir, input logic [AW-1:0] ia,
                       input bit dr, input bit dwe, input logic [AW-1:0] da,
                       input logic [DW-1:0] dwd, input bit ack, input logic [DW-1:0] rd);
        bit d_win;
        @(posedge clk);
        #1;
        rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe;
        d_addr = da; d_wdata = dwd; m_ack = ack; m_rdata = rd;

        d_win    = dr && !(GUARD && ir && (streak == SMAX));
        e_dg     = r && !t_busy && d_win;
        e_ig     = r && !t_busy && ir && !d_win;
        e_busy   = t_busy;
        e_mreq   = t_busy && !t_acked;
        e_mwe    = e_mreq && t_we;
        e_maddr  = t_addr;
        e_mwdata = t_wdata;
        e_iv     = t_acked && !t_d;
        e_dv     = t_acked && t_d;
        e_ir     = last_i;
        e_dr     = last_d;

        @(negedge clk);
        #1;
        if (!r) begin
            t_busy = 0; t_acked = 0; last_i = '0; last_d = '0; streak = 0; mk = 1;
        end else if (e_ig || e_dg) begin
            t_busy = 1; t_acked = 0; t_d = e_dg; t_we = e_dg && dwe;
            t_addr = e_dg ? da : ia; t_wdata = dwd;
            if (GUARD) begin
                if (e_dg && ir) streak = (streak + 1 > SMAX) ? SMAX : streak + 1;
                else if (e_ig) streak = 0;
            end
        end else if (t_busy && !t_acked) begin
            if (ack) begin
                t_acked = 1;
                if (t_d) last_d = t_we ? '0 : rd;
                else     last_i = rd;
            end
        end else if (t_acked) begin
            t_busy = 0; t_acked = 0;
        end
    endtask

    task automatic idle_cyc();
        cyc(1, 0, '0, 0, 0, '0, '0, 0, '0);
    endtask

    initial begin
        rst = 0; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;

        // Reset state
        cyc(0, 0, '0, 0, 0, '0, '0, 0, '0);
        cyc(0, 1, 16'h0001, 1, 1, 16'h0002, 16'h0003, 1, 16'h0004);
        chk("rst_gnt",   {i_gnt, d_gnt}, 0);
        cyc(1, 0, '0, 0, 0, '0, '0, 0, '0);
        chk("rst_busy",  busy, 0);
        chk("rst_m_req", m_req, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);

        // Single I read, ack on second REQ cycle
        cyc(1, 1, 16'h0010, 0, 0, '0, '0, 0, '0);
        chk("i_read_gnt", i_gnt, 1);
        cyc(1, 0, '0, 0, 0, '0, '0, 0, '0);
        chk("i_read_mreq1", m_req, 1);
        chk("i_read_addr", m_addr, 16'h0010);
        cyc(1, 0, '0, 0, 0, '0, '0, 1, 16'hBEEF);
        chk("i_read_mreq2", m_req, 1);
        idle_cyc();
        chk("i_read_valid", i_valid, 1);
        chk("i_read_data", i_rdata, 16'hBEEF);
        idle_cyc();
        chk("i_read_done", {i_valid, busy}, 0);

        // D write with immediate ack
        cyc(1, 0, '0, 1, 1, 16'h0200, 16'h1234, 0, '0);
        chk("d_wr_gnt", d_gnt, 1);
        cyc(1, 0, '0, 0, 0, '0, '0, 1, 16'h9999);
        chk("d_wr_we", m_we, 1);
        chk("d_wr_wdata", m_wdata, 16'h1234);
        idle_cyc();
        chk("d_wr_valid", d_valid, 1);
        chk("d_wr_rdata", d_rdata, 0);

        // Simultaneous requests: D first, I right after D's RESP
        cyc(1, 1, 16'h0020, 1, 0, 16'h0030, '0, 0, '0);
        chk("both_d_gnt", d_gnt, 1);
        chk("both_i_gnt", i_gnt, 0);
        cyc(1, 1, 16'h0020, 0, 0, '0, '0, 1, 16'h5555);
        cyc(1, 1, 16'h0020, 0, 0, '0, '0, 0, '0);
        chk("both_d_valid", d_valid, 1);
        chk("both_d_rdata", d_rdata, 16'h5555);
        chk("both_no_gnt_resp", i_gnt, 0);
        cyc(1, 1, 16'h0020, 0, 0, '0, '0, 0, '0);
        chk("both_i_next", i_gnt, 1);
        cyc(1, 0, '0, 0, 0, '0, '0, 1, 16'h7777);
        idle_cyc();
        chk("both_i_data", i_rdata, 16'h7777);

        // Starvation: I held, D re-requesting every IDLE
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 16'h0300, 1, 0, AW'(16'h0400 + k), '0, 0, '0);
            chk("starve_d_gnt", d_gnt, (GUARD && k == 4) ? 0 : 1);
            cyc(1, 1, 16'h0300, 1, 0, '0, '0, 1, DW'(16'h0100 + k));
            cyc(1, 1, 16'h0300, 1, 0, '0, '0, 0, '0);
        end

        // Reset in REQ without ack, then a fresh I request right after release
        idle_cyc();
        cyc(1, 1, 16'h0040, 0, 0, '0, '0, 0, '0);
        chk("rst_mid_gnt", i_gnt, 1);
        cyc(1, 0, '0, 0, 0, '0, '0, 0, '0);
        cyc(0, 0, '0, 0, 0, '0, '0, 0, '0);
        cyc(1, 1, 16'h0044, 0, 0, '0, '0, 1, 16'hDEAD);
        chk("rst_mid_mreq", m_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", i_valid, 0);
        chk("rst_mid_regnt", i_gnt, 1);
        chk("rst_mid_rdata", i_rdata, 0);
        cyc(1, 0, '0, 0, 0, '0, '0, 1, 16'hA5A5);
        idle_cyc();
        chk("rst_fresh_valid", i_valid, 1);
        chk("rst_fresh_data", i_rdata, 16'hA5A5);

        // Stray ack in IDLE
        idle_cyc();
        cyc(1, 0, '0, 0, 0, '0, '0, 1, 16'hFFFF);
        chk("stray_busy", busy, 0);
        idle_cyc();
        chk("stray_quiet", {i_valid, d_valid, busy, m_req}, 0);
        chk("stray_rdata", i_rdata, 16'hA5A5);

        // Randomized traffic, occasional reset
        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(0, 59) != 0),
                1'($urandom_range(0, 1)), AW'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                DW'($urandom), ($urandom_range(0, 9) < 4), DW'($urandom));
        end
        idle_cyc();
        idle_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, address width.
REQ-002 SHALL provide parameter DATA_W, default 16, data width.
REQ-003 SHALL provide parameter STARVE_MAX, default 4, consecutive D grants allowed while I waits.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted
- i_valid  out  1  fetch data valid pulse
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write data
- d_gnt  out  1  data request accepted
- d_valid  out  1  data completion pulse
- d_rdata  out  DATA_W  data read data
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_ack  in  1  memory done, m_rdata valid this cycle
- m_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight

Function
REQ-006 SHALL implement FSM IDLE -> REQ -> RESP -> IDLE, with one transaction in flight at a time.
REQ-007 In IDLE, SHALL arbitrate combinationally:
- assert exactly one of i_gnt/d_gnt for one cycle when any request is high;
- latch the winner's addr/we/wdata at that edge;
- enter REQ.
REQ-008 SHALL give D priority over I when both request, subject to REQ-015.
REQ-009 In REQ, SHALL hold m_req=1 and keep m_addr/m_we/m_wdata stable until the cycle m_ack=1; on m_ack, SHALL capture m_rdata and enter RESP.
REQ-010 In RESP, SHALL pulse the owner's valid for exactly one cycle, then return to IDLE, with no arbitration in RESP.
REQ-011 For a D write, d_rdata SHALL be 0 during d_valid; i_rdata/d_rdata SHALL hold their last value outside valid pulses.
REQ-012 Minimum latency SHALL be: gnt at cycle 0, m_req at cycles 1..k (m_ack at k), valid at k+1, next gnt possible at k+2.
REQ-013 SHALL ignore requesters whose req is deasserted before gnt; no gnt, busy, or m_req results.
REQ-014 SHALL ignore m_ack outside REQ; busy SHALL be 1 in REQ and RESP.
REQ-015 Starvation counter (REQ-020):
- increments (saturating at STARVE_MAX) on each d_gnt while i_req=1;
- clears on i_gnt;
- when count==STARVE_MAX and both requests are high, I SHALL win.

Reset
REQ-016 While rst=0 at a rising edge, state SHALL become IDLE and all outputs SHALL be 0, including rdata registers and the starvation counter.
REQ-017 Reset during REQ or RESP SHALL drop m_req the next cycle, discard the transaction and emit no valid.
REQ-018 Requests sampled in the first cycle after reset release SHALL be arbitrated normally.

Configuration
REQ-019 Macro ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-020 Defined: REQ-015 behaviour applies. Undefined: strict D priority with no counter logic, and I may starve indefinitely.

Verification
REQ-021 Single I read: i_req=1, i_addr=0x0010, m_ack at 2nd REQ cycle with m_rdata=0xBEEF -> i_gnt at cycle 0, m_req cycles 1-2 with m_addr=0x0010, i_valid=1 with i_rdata=0xBEEF at cycle 3.
REQ-022 D write: d_we=1, d_addr=0x0200, d_wdata=0x1234, m_ack immediately -> m_we=1, m_wdata=0x1234 at cycle 1, d_valid=1 with d_rdata=0 at cycle 2.
REQ-023 Simultaneous: both requests high at cycle 0 -> d_gnt=1, i_gnt=0; I is granted in the first IDLE after D's RESP.
REQ-024 Starvation with macro defined: i_req held, d_req continuously re-asserted -> 4 D grants, 5th grant to I, counter reset. Without macro -> all grants to D.
REQ-025 Reset mid-op: rst=0 in REQ with m_ack never asserted -> m_req=0, busy=0 next cycle, no valid pulse, and a fresh I request after release completes normally.
REQ-026 Stray ack: m_ack=1 in IDLE -> no valid and no state change.
